// File: rtl/pic_pkg.sv
// pic_pkg: shared FSM type, sizing helper and spurious-vector constant for the PIC
package pic_pkg;
  typedef enum logic [1:0] {IDLE, ACK1, ACK2} pic_state_t;
  localparam int N_IRQ_DEFAULT = 8;
  localparam int SPURIOUS_ID = N_IRQ_DEFAULT - 1;
  function automatic int clog2_safe(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/pic_priority_controller_resolver.sv
// prio_rotate_resolver: first set request in rotating order starting just after the lowest-priority pointer
module prio_rotate_resolver import pic_pkg::*; #(
  parameter int N_IRQ = 8,
  parameter int ID_W = clog2_safe(N_IRQ)
) (
  input  logic [N_IRQ-1:0] req,
  input  logic [ID_W-1:0]  lp,
  output logic             found,
  output logic [ID_W-1:0]  id,
  output logic [N_IRQ-1:0] onehot
);
  localparam logic [ID_W:0] NN = (ID_W+1)'(N_IRQ);
  logic [ID_W:0] idx;
  // walk lp+1, lp+2, ... mod N_IRQ; the first hit is the highest-ranked request
  always_comb begin
    found = 1'b0;
    id = '0;
    idx = '0;
    for (int k = 1; k <= N_IRQ; k++) begin
      idx = {1'b0, lp} + (ID_W+1)'(k);
      idx = (idx >= NN) ? idx - NN : idx;
      if (!found && req[idx[ID_W-1:0]]) begin
        found = 1'b1;
        id = idx[ID_W-1:0];
      end
    end
    onehot = found ? N_IRQ'(1) << id : '0;
  end
endmodule

// File: rtl/pic_priority_controller.sv
// pic_priority_controller: IRR/ISR state, rotating/nested priority resolution and two-pulse INTA handshake
module pic_priority_controller import pic_pkg::*; #(
  parameter int N_IRQ = 8,
  parameter int ID_W = clog2_safe(N_IRQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             edge_mode,
  input  logic [N_IRQ-1:0] imr,
  input  logic             rotate_mode,
  input  logic             aeoi,
  input  logic             inta,
  input  logic             eoi,
  input  logic             eoi_specific,
  input  logic [ID_W-1:0]  eoi_id,
  input  logic             set_prio,
  input  logic [ID_W-1:0]  prio_id,
  output logic             int_out,
  output logic             vec_valid,
  output logic [ID_W-1:0]  vec_id,
  output logic [N_IRQ-1:0] irr,
  output logic [N_IRQ-1:0] isr
);
  localparam logic [ID_W-1:0] LAST = ID_W'(N_IRQ - 1);
  localparam logic [ID_W:0] NN = (ID_W+1)'(N_IRQ);
  pic_state_t state, state_nx;
  logic [N_IRQ-1:0] irq_q, cand_oh, hi_oh, isr_clr, isr_set, irr_clr;
  logic [ID_W-1:0] lp, win, cand_id, hi_id;
  logic spur, cand_found, hi_found, ack1, ack2, nsp_eoi, sp_eoi_ok, prio_ok, aeoi_hit, int_nx;
  function automatic logic [ID_W:0] rank_of(input logic [ID_W-1:0] x, input logic [ID_W-1:0] p);
    logic [ID_W:0] r;
    r = {1'b0, x} + NN - {1'b0, p} - (ID_W+1)'(1);
    return (r >= NN) ? r - NN : r;
  endfunction
  prio_rotate_resolver #(.N_IRQ(N_IRQ), .ID_W(ID_W)) u_cand (
    .req(irr & ~imr),
    .lp(lp),
    .found(cand_found),
    .id(cand_id),
    .onehot(cand_oh)
  );
  prio_rotate_resolver #(.N_IRQ(N_IRQ), .ID_W(ID_W)) u_hi (
    .req(isr),
    .lp(lp),
    .found(hi_found),
    .id(hi_id),
    .onehot(hi_oh)
  );
  // handshake sequencing plus the set/clear masks every register update is built from
  always_comb begin
    ack1 = state == IDLE && inta;
    ack2 = state == ACK1 && inta;
    state_nx = ack1 ? ACK1 : ack2 ? ACK2 : state == ACK1 ? ACK1 : IDLE;
    nsp_eoi = eoi && !eoi_specific && hi_found;
    sp_eoi_ok = eoi && eoi_specific && {1'b0, eoi_id} < NN;
    prio_ok = set_prio && {1'b0, prio_id} < NN;
    aeoi_hit = ack2 && aeoi && !spur;
    isr_clr = (nsp_eoi ? hi_oh : '0) | (sp_eoi_ok ? N_IRQ'(1) << eoi_id : '0) | (aeoi_hit ? N_IRQ'(1) << win : '0);
    isr_set = ack1 ? cand_oh : '0;
    irr_clr = ack1 && edge_mode ? cand_oh : '0;
    int_nx = !ack1 && cand_found && (!hi_found || rank_of(cand_id, lp) < rank_of(hi_id, lp));
  end
  // FSM state register
  always_ff @(posedge clk) state <= !rst_n ? IDLE : state_nx;
  // request/in-service registers, priority pointer, frozen winner and CPU-side outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_q <= '0;
      irr <= '0;
      isr <= '0;
      lp <= LAST;
      win <= '0;
      spur <= 1'b0;
      int_out <= 1'b0;
      vec_valid <= 1'b0;
      vec_id <= '0;
    end else begin
      irq_q <= irq_in;
      irr <= edge_mode ? (irr & ~irr_clr) | (irq_in & ~irq_q) : irq_in;
      isr <= (isr & ~isr_clr) | isr_set;
      lp <= prio_ok ? prio_id : nsp_eoi && rotate_mode ? hi_id : aeoi_hit && rotate_mode ? win : lp;
      if (ack1) begin
        win <= cand_found ? cand_id : LAST;
        spur <= !cand_found;
      end
      int_out <= int_nx;
      vec_valid <= ack2;
      if (ack2) vec_id <= win;
    end
  end
endmodule
